ad_capture_front: RTL and testbench
===================================

# ad_capture_front

Per-shot ADC acquisition front end in the `clk_ad_180M` domain. It synchronises the pulser trigger, waits a programmable delay, and captures a fixed-length window of 8-bit ADC samples. Samples are packed in pairs into 16-bit words and pushed into the write side of the dual-clock sample FIFO feeding the USB path. A built-in ramp test-pattern source replaces the ADC for bench and bring-up.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `i_trig` synchroniser (2..3).
- `TEST_START`, 8'd251: test-pattern value loaded on every detected trigger edge.
- `TEST_WRAP`, 8'd10: test-pattern value after which the pattern returns to 0.

Ports:
- `clk_ad_180M`  in  1  ADC sample clock.
- `i_rst_n`  in  1  reset; reset i_rst_n, asynchronous, active-low; clock clk_ad_180M.
- `i_trig`  in  1  pulser trigger, asynchronous (50 MHz origin), rising-edge significant.
- `i_ad_data`  in  8  ADC sample, valid at every `clk_ad_180M` rising edge.
- `i_test_mode`  in  1  1 = capture test pattern instead of ADC; quasi-static, change only while `o_busy`=0.
- `i_delay`  in  16  cycles to wait after trigger before capture; sampled on trigger accept.
- `i_recv_count`  in  16  16-bit words per shot; sampled on trigger accept.
- `i_fifo_full`  in  1  FIFO write-side full.
- `o_wr`  out  1  one-cycle write strobe for `o_wr_data`.
- `o_wr_data`  out  16  packed word: first sample in [7:0], second sample in [15:8].
- `o_busy`  out  1  high from trigger accept until the last word is issued.
- `o_overflow`  out  1  sticky: at least one word of the current shot was dropped because the FIFO was full.
- `o_shot_cnt`  out  8  accepted-trigger counter, wraps 255→0.

## Operation
- **Input registering.** `i_ad_data` is registered once into `s_ad`. In test mode, `s_ad` takes the pattern register instead.
- **Test pattern.** Free-running. Loads `TEST_START` on every detected trigger edge, busy or not. Otherwise increments by 1, with value `TEST_WRAP` followed by 0. From `TEST_START`=251 the sequence is 251..255,0..10,0..10,...
- **Trigger detection.** `i_trig` passes through the `SYNC_STAGES` synchroniser, then a previous-value register. Edge = synced & ~prev.
- **FSM states:** IDLE, DELAY, CAPTURE.
  - IDLE + edge: latch `i_delay` and `i_recv_count`, clear `o_overflow`, increment `o_shot_cnt`, set `o_busy`. Next state is DELAY if delay≠0, else CAPTURE. If `i_recv_count`=0, return to IDLE with no writes; `o_busy` is high for one cycle.
  - DELAY: a down-counter runs for exactly `i_delay` cycles, then the FSM goes to CAPTURE.
  - CAPTURE: one `s_ad` sample is taken per clock. Odd samples are held as the low byte. Each even sample forms a word, and the word counter increments. After word N, go to IDLE and clear `o_busy`.
- **Trigger edges while busy** are ignored: no restart and no count increment. The pattern reload still happens.
- **FIFO full.** If `i_fifo_full`=1 in the cycle a word is formed, the word is dropped: `o_wr` stays 0 and `o_overflow` is set. The word counter still advances, so the window length is fixed in time.
- **Arithmetic.** Delay and word counters are 16 bits and cannot wrap, because they stop at their terminal value. `o_shot_cnt` is modulo 256.
- **Reset.** Reset mid-operation aborts the shot: FSM to IDLE and all counters cleared. No partial word is emitted.

## Timing
- **Reset values:** `o_wr`=0, `o_wr_data`=0, `o_busy`=0, `o_overflow`=0, `o_shot_cnt`=0. Synchroniser, prev register and pattern are 0, so an `i_trig` already high at reset release is detected as one edge.
- **Trigger latency.** Let E0 be the first clock edge sampling `i_trig` high. The edge is accepted at edge E0+`SYNC_STAGES`; `o_busy` is high after that edge.
- **Capture entry.** CAPTURE is entered at Ec = accept edge + `i_delay`.
- **Sample alignment.** The sample taken at edge Ec+k is the `s_ad` value that was registered from the input at edge Ec+k-1.
- **Write cadence.** Word j (j=1..N) is registered at edge Ec+2j, with `o_wr`=1 for exactly the following cycle. Write period is 2 cycles (90 Mword/s).
- **Shot end.** `o_busy` goes 0 after edge Ec+2N. A new edge is accepted from edge Ec+2N+1 onward.
- **Pulse width.** Minimum `i_trig` high and low time: `SYNC_STAGES`+1 clocks.

## Test plan
- **Basic shot.** Test mode, `i_delay`=0, `i_recv_count`=4, one trigger pulse → exactly 4 `o_wr` strobes, 2 cycles apart. Words follow the ramp: first word low byte = first `s_ad` after Ec. `o_shot_cnt`=1; `o_busy` falls after the 4th word.
- **Delay and latency.** `i_delay`=100, `i_recv_count`=512, ADC driven with a counter → first `o_wr` exactly `SYNC_STAGES`+100+2 edges after E0. 512 strobes total; byte order checked, low byte = earlier sample.
- **FIFO full.** Force `i_fifo_full`=1 for words 3..5 of 8 → 5 strobes issued and `o_overflow`=1 until the next accepted trigger. Last strobe still at Ec+16.
- **Retrigger while busy.** Second trigger mid-CAPTURE → no restart, `o_shot_cnt` unchanged, word count unchanged. A third trigger after idle is accepted and clears `o_overflow`.
- **Zero length.** `i_recv_count`=0 → no `o_wr`, one-cycle `o_busy`, `o_shot_cnt` increments.
- **Reset mid-shot.** Assert `i_rst_n`=0 during CAPTURE → all outputs 0 immediately. After release with `i_trig` held high, one shot starts.

Source files
------------

// File: rtl/ad_capture_front.sv
// Per-shot ADC capture front end: trigger sync, programmable delay, fixed-length
// window of 8-bit samples packed in pairs into 16-bit FIFO writes, plus ramp test source.
module ad_capture_front #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TEST_START  = 8'd251,
  parameter logic [7:0]  TEST_WRAP   = 8'd10
) (
  input  logic        clk_ad_180M,
  input  logic        i_rst_n,
  input  logic        i_trig,
  input  logic [7:0]  i_ad_data,
  input  logic        i_test_mode,
  input  logic [15:0] i_delay,
  input  logic [15:0] i_recv_count,
  input  logic        i_fifo_full,
  output logic        o_wr,
  output logic [15:0] o_wr_data,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [7:0]  o_shot_cnt
);

  typedef enum logic [1:0] {StIdle, StDelay, StCapture} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev_q;
  logic                   trig_edge;
  logic [7:0]             pat_q;
  logic [7:0]             s_ad;
  logic [7:0]             lo_q;
  logic [15:0]            dly_cnt_q;
  logic [15:0]            len_q;
  logic [15:0]            wrd_cnt_q;
  logic                   phase_q;
  logic                   busy_q;
  logic                   accept;
  logic                   last_word;

  assign trig_edge = sync_q[SYNC_STAGES-1] & ~trig_prev_q;
  assign last_word = (wrd_cnt_q == len_q - 16'd1);
  assign o_busy    = busy_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_edge) begin
          accept = 1'b1;
          // A zero-length shot is counted but never leaves idle.
          if (i_recv_count == 16'd0) begin
            state_d = StIdle;
          end else if (i_delay != 16'd0) begin
            state_d = StDelay;
          end else begin
            state_d = StCapture;
          end
        end
      end
      StDelay: begin
        if (dly_cnt_q == 16'd1) state_d = StCapture;
      end
      StCapture: begin
        if (phase_q && last_word) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      trig_prev_q <= 1'b0;
      pat_q       <= '0;
      s_ad        <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_trig};
      trig_prev_q <= sync_q[SYNC_STAGES-1];
      // Pattern reloads on every detected edge, even while a shot is running.
      if (trig_edge) begin
        pat_q <= TEST_START;
      end else if (pat_q == TEST_WRAP) begin
        pat_q <= '0;
      end else begin
        pat_q <= pat_q + 8'd1;
      end
      s_ad <= i_test_mode ? pat_q : i_ad_data;
    end
  end

  always_ff @(posedge clk_ad_180M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_cnt_q  <= '0;
      len_q      <= '0;
      wrd_cnt_q  <= '0;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      o_wr       <= 1'b0;
      o_wr_data  <= '0;
      o_overflow <= 1'b0;
      o_shot_cnt <= '0;
    end else begin
      o_wr <= 1'b0;
      if (accept) begin
        dly_cnt_q  <= i_delay;
        len_q      <= i_recv_count;
        wrd_cnt_q  <= '0;
        phase_q    <= 1'b0;
        busy_q     <= 1'b1;
        o_overflow <= 1'b0;
        o_shot_cnt <= o_shot_cnt + 8'd1;
      end else if (state_q == StIdle) begin
        busy_q <= 1'b0;
      end
      if (state_q == StDelay) dly_cnt_q <= dly_cnt_q - 16'd1;
      if (state_q == StCapture) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          lo_q <= s_ad;
        end else begin
          // Word slot advances even when dropped so the window stays fixed in time.
          wrd_cnt_q <= wrd_cnt_q + 16'd1;
          if (i_fifo_full) begin
            o_overflow <= 1'b1;
          end else begin
            o_wr      <= 1'b1;
            o_wr_data <= {s_ad, lo_q};
          end
          if (last_word) busy_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ad_capture_front.sv
// Directed self-checking bench for ad_capture_front; edge k in a shot is counted from E0,
// the first clock edge that samples the trigger high.
module tb_ad_capture_front;

  logic        clk_ad_180M;
  logic        i_rst_n;
  logic        i_trig;
  logic [7:0]  i_ad_data;
  logic        i_test_mode;
  logic [15:0] i_delay;
  logic [15:0] i_recv_count;
  logic        i_fifo_full;
  logic        o_wr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_overflow;
  logic [7:0]  o_shot_cnt;

  int          n_checks;
  int          n_fail;
  int          wr_k[$];
  logic [15:0] wr_d[$];
  bit          busy_log[0:1199];
  bit          ovf_log[0:1199];

  ad_capture_front #(
    .SYNC_STAGES(2),
    .TEST_START (8'd251),
    .TEST_WRAP  (8'd10)
  ) dut (
    .clk_ad_180M (clk_ad_180M),
    .i_rst_n     (i_rst_n),
    .i_trig      (i_trig),
    .i_ad_data   (i_ad_data),
    .i_test_mode (i_test_mode),
    .i_delay     (i_delay),
    .i_recv_count(i_recv_count),
    .i_fifo_full (i_fifo_full),
    .o_wr        (o_wr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow),
    .o_shot_cnt  (o_shot_cnt)
  );

  initial clk_ad_180M = 1'b0;
  always #5 clk_ad_180M = ~clk_ad_180M;

  // Call at a negedge. Iteration k observes outputs after edge k and drives edge k+1;
  // i_ad_data registered at edge m equals m, trigger high for edges [0, hold) and
  // [retrig, retrig+4), FIFO full during edges (full_lo, full_hi+1].
  task automatic run_shot(input logic tm, input logic [15:0] dly, input logic [15:0] len,
                          input int ncyc, input int hold, input int retrig,
                          input int full_lo, input int full_hi);
    wr_k.delete();
    wr_d.delete();
    i_test_mode  = tm;
    i_delay      = dly;
    i_recv_count = len;
    i_ad_data    = 8'd0;
    i_fifo_full  = 1'b0;
    i_trig       = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_ad_180M);
      busy_log[k] = o_busy;
      ovf_log[k]  = o_overflow;
      if (o_wr) begin
        wr_k.push_back(k);
        wr_d.push_back(o_wr_data);
      end
      i_ad_data   = 8'(k + 1);
      i_fifo_full = (k >= full_lo) && (k <= full_hi);
      i_trig      = (k + 1 < hold) || (retrig > 0 && k + 1 >= retrig && k + 1 < retrig + 4);
    end
    i_trig      = 1'b0;
    i_fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", o_wr); end
    n_checks++; if (o_wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0000", o_wr_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    n_checks++; if (o_shot_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_shot_cnt: got %0d want 0", o_shot_cnt); end
    i_rst_n = 1'b1;
    repeat (5) @(negedge clk_ad_180M);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_basic();
    run_shot(1'b1, 16'd0, 16'd4, 16, 4, 0, 1000, -1);
    n_checks++; if (busy_log[1] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_k1: got %b want 0", busy_log[1]); end
    n_checks++; if (busy_log[2] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_k2: got %b want 1", busy_log[2]); end
    n_checks++; if (busy_log[9] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_k9: got %b want 1", busy_log[9]); end
    n_checks++; if (busy_log[10] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_k10: got %b want 0", busy_log[10]); end
    n_checks++;
    if (wr_k.size() != 4) begin
      n_fail++; $display("FAIL basic_wr_count: got %0d want 4", wr_k.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++; if (wr_k[j] != 4 + 2 * j) begin n_fail++; $display("FAIL basic_wr_time%0d: got %0d want %0d", j, wr_k[j], 4 + 2 * j); end
      end
      n_checks++; if (wr_d[0][15:8] !== 8'd251) begin n_fail++; $display("FAIL basic_word1_hi: got %0d want 251", wr_d[0][15:8]); end
      n_checks++; if (wr_d[1] !== 16'hFDFC) begin n_fail++; $display("FAIL basic_word2: got %h want fdfc", wr_d[1]); end
      n_checks++; if (wr_d[2] !== 16'hFFFE) begin n_fail++; $display("FAIL basic_word3: got %h want fffe", wr_d[2]); end
      n_checks++; if (wr_d[3] !== 16'h0100) begin n_fail++; $display("FAIL basic_word4: got %h want 0100", wr_d[3]); end
    end
    n_checks++; if (o_shot_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_shot_cnt: got %0d want 1", o_shot_cnt); end
  endtask

  task automatic test_delay();
    int bad_data;
    int bad_time;
    logic [15:0] exp_w;
    run_shot(1'b0, 16'd100, 16'd512, 1130, 4, 0, 1000000, -1);
    n_checks++; if (busy_log[2] !== 1'b1) begin n_fail++; $display("FAIL delay_busy_accept: got %b want 1", busy_log[2]); end
    n_checks++; if (busy_log[1125] !== 1'b1) begin n_fail++; $display("FAIL delay_busy_k1125: got %b want 1", busy_log[1125]); end
    n_checks++; if (busy_log[1126] !== 1'b0) begin n_fail++; $display("FAIL delay_busy_end: got %b want 0", busy_log[1126]); end
    n_checks++;
    if (wr_k.size() != 512) begin
      n_fail++; $display("FAIL delay_wr_count: got %0d want 512", wr_k.size());
    end else begin
      n_checks++; if (wr_k[0] != 104) begin n_fail++; $display("FAIL delay_first_wr: got k=%0d want k=104", wr_k[0]); end
      n_checks++; if (wr_k[511] != 1126) begin n_fail++; $display("FAIL delay_last_wr: got k=%0d want k=1126", wr_k[511]); end
      bad_data = 0;
      bad_time = 0;
      for (int j = 1; j <= 512; j++) begin
        exp_w = {8'(100 + 2 * j + 1), 8'(100 + 2 * j)};
        if (wr_d[j-1] !== exp_w) bad_data++;
        if (wr_k[j-1] != 102 + 2 * j) bad_time++;
      end
      n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL delay_words: got %0d bad words (first %h) want 0 (first 6766)", bad_data, wr_d[0]); end
      n_checks++; if (bad_time != 0) begin n_fail++; $display("FAIL delay_cadence: got %0d off-slot strobes want 0", bad_time); end
    end
    n_checks++; if (o_shot_cnt !== 8'd2) begin n_fail++; $display("FAIL delay_shot_cnt: got %0d want 2", o_shot_cnt); end
  endtask

  task automatic test_fifo_full();
    run_shot(1'b0, 16'd0, 16'd8, 22, 4, 0, 7, 11);
    n_checks++; if (ovf_log[7] !== 1'b0) begin n_fail++; $display("FAIL fifo_ovf_before: got %b want 0", ovf_log[7]); end
    n_checks++; if (ovf_log[8] !== 1'b1) begin n_fail++; $display("FAIL fifo_ovf_set: got %b want 1", ovf_log[8]); end
    n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL fifo_ovf_sticky: got %b want 1", o_overflow); end
    n_checks++;
    if (wr_k.size() != 5) begin
      n_fail++; $display("FAIL fifo_wr_count: got %0d want 5", wr_k.size());
    end else begin
      n_checks++; if (wr_k[2] != 14) begin n_fail++; $display("FAIL fifo_word6_time: got k=%0d want k=14", wr_k[2]); end
      n_checks++; if (wr_k[4] != 18) begin n_fail++; $display("FAIL fifo_last_time: got k=%0d want k=18", wr_k[4]); end
      n_checks++; if (wr_d[0] !== 16'h0302) begin n_fail++; $display("FAIL fifo_word1: got %h want 0302", wr_d[0]); end
      n_checks++; if (wr_d[2] !== 16'h0D0C) begin n_fail++; $display("FAIL fifo_word6: got %h want 0d0c", wr_d[2]); end
    end
    n_checks++; if (o_shot_cnt !== 8'd3) begin n_fail++; $display("FAIL fifo_shot_cnt: got %0d want 3", o_shot_cnt); end
  endtask

  task automatic test_retrigger();
    run_shot(1'b1, 16'd0, 16'd8, 22, 4, 9, 5, 5);
    n_checks++; if (busy_log[17] !== 1'b1) begin n_fail++; $display("FAIL retrig_busy_k17: got %b want 1", busy_log[17]); end
    n_checks++; if (busy_log[18] !== 1'b0) begin n_fail++; $display("FAIL retrig_busy_end: got %b want 0", busy_log[18]); end
    n_checks++; if (o_shot_cnt !== 8'd4) begin n_fail++; $display("FAIL retrig_shot_cnt: got %0d want 4", o_shot_cnt); end
    n_checks++;
    if (wr_k.size() != 7) begin
      n_fail++; $display("FAIL retrig_wr_count: got %0d want 7", wr_k.size());
    end else begin
      n_checks++; if (wr_k[6] != 18) begin n_fail++; $display("FAIL retrig_last_time: got k=%0d want k=18", wr_k[6]); end
      n_checks++; if (wr_d[3] !== 16'h0302) begin n_fail++; $display("FAIL retrig_word5: got %h want 0302", wr_d[3]); end
      n_checks++; if (wr_d[4] !== 16'hFCFB) begin n_fail++; $display("FAIL retrig_reload_word6: got %h want fcfb", wr_d[4]); end
    end
    n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL retrig_ovf: got %b want 1", o_overflow); end
    run_shot(1'b1, 16'd0, 16'd2, 10, 4, 0, 1000, -1);
    n_checks++; if (ovf_log[1] !== 1'b1) begin n_fail++; $display("FAIL third_ovf_before: got %b want 1", ovf_log[1]); end
    n_checks++; if (ovf_log[2] !== 1'b0) begin n_fail++; $display("FAIL third_ovf_cleared: got %b want 0", ovf_log[2]); end
    n_checks++; if (o_shot_cnt !== 8'd5) begin n_fail++; $display("FAIL third_shot_cnt: got %0d want 5", o_shot_cnt); end
    n_checks++; if (wr_k.size() != 2) begin n_fail++; $display("FAIL third_wr_count: got %0d want 2", wr_k.size()); end
  endtask

  task automatic test_zero_length();
    run_shot(1'b0, 16'd5, 16'd0, 20, 4, 0, 1000, -1);
    n_checks++; if (busy_log[1] !== 1'b0) begin n_fail++; $display("FAIL zero_busy_k1: got %b want 0", busy_log[1]); end
    n_checks++; if (busy_log[2] !== 1'b1) begin n_fail++; $display("FAIL zero_busy_k2: got %b want 1", busy_log[2]); end
    n_checks++; if (busy_log[3] !== 1'b0) begin n_fail++; $display("FAIL zero_busy_k3: got %b want 0", busy_log[3]); end
    n_checks++; if (wr_k.size() != 0) begin n_fail++; $display("FAIL zero_wr_count: got %0d want 0", wr_k.size()); end
    n_checks++; if (o_shot_cnt !== 8'd6) begin n_fail++; $display("FAIL zero_shot_cnt: got %0d want 6", o_shot_cnt); end
  endtask

  task automatic test_reset_mid_shot();
    i_test_mode  = 1'b0;
    i_delay      = 16'd0;
    i_recv_count = 16'd8;
    i_ad_data    = 8'h5A;
    i_trig       = 1'b1;
    repeat (9) @(negedge clk_ad_180M);
    n_checks++; if (o_wr !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wr: got %b want 1", o_wr); end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", o_wr); end
    n_checks++; if (o_wr_data !== 16'h0000) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0000", o_wr_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_checks++; if (o_shot_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_shot_cnt: got %0d want 0", o_shot_cnt); end
    repeat (3) @(negedge clk_ad_180M);
    i_rst_n = 1'b1;
    run_shot(1'b0, 16'd0, 16'd2, 12, 4, 0, 1000, -1);
    n_checks++; if (busy_log[1] !== 1'b0) begin n_fail++; $display("FAIL rst_rel_busy_k1: got %b want 0", busy_log[1]); end
    n_checks++; if (busy_log[2] !== 1'b1) begin n_fail++; $display("FAIL rst_rel_busy_k2: got %b want 1", busy_log[2]); end
    n_checks++; if (o_shot_cnt !== 8'd1) begin n_fail++; $display("FAIL rst_rel_shot_cnt: got %0d want 1", o_shot_cnt); end
    n_checks++; if (wr_k.size() != 2) begin n_fail++; $display("FAIL rst_rel_wr_count: got %0d want 2", wr_k.size()); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    i_rst_n      = 1'b0;
    i_trig       = 1'b0;
    i_ad_data    = 8'd0;
    i_test_mode  = 1'b0;
    i_delay      = 16'd0;
    i_recv_count = 16'd0;
    i_fifo_full  = 1'b0;
    repeat (3) @(negedge clk_ad_180M);
    test_reset();
    test_basic();
    test_delay();
    test_fifo_full();
    test_retrigger();
    test_zero_length();
    test_reset_mid_shot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
